// File: rtl/ctrl_counter_pkg.sv
// Shared types for the counter bank: per-channel command encoding and the
// trigger priority decoder used by every channel.
package ctrl_counter_pkg;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_UP,
      CMD_DOWN,
      CMD_LOAD,
      CMD_RST
   } cmd_e;

   // Priority: rst > load > (up & down cancel out) > up > down.
   function automatic cmd_e cmd_decode(input logic rst,
                                       input logic load,
                                       input logic up,
                                       input logic down);
      if (rst)
         return CMD_RST;
      else if (load)
         return CMD_LOAD;
      else if (up && !down)
         return CMD_UP;
      else if (down && !up)
         return CMD_DOWN;
      else
         return CMD_NONE;
   endfunction

endpackage

// File: rtl/ctrl_counter_chan.sv
// One counter channel: count register, step adder/subtractor with carry and
// borrow detection, wrap or saturate handling, terminal-count pulse and the
// sticky saturation flag.
module ctrl_counter_chan
   import ctrl_counter_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STEP_W = 8
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  cmd_e              cmd,
   input  logic [WIDTH-1:0]  load_value,
   input  logic [STEP_W-1:0] step,
   input  logic              mode_sat,
   output logic [WIDTH-1:0]  count,
   output logic              tc_pulse,
   output logic              sat_flag
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             sat_q, sat_d;

   // The extra top bit of sum/diff is the carry (up) or borrow (down).
   logic [WIDTH:0] step_ext;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
   assign sum      = {1'b0, count_q} + step_ext;
   assign diff     = {1'b0, count_q} - step_ext;

   // Next-state: apply the decoded command; mode_sat is sampled with it.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      count_d = count_q;
      tc_d    = 1'b0;
      sat_d   = sat_q;
      unique case (cmd)
         CMD_RST: begin
            count_d = '0;
            sat_d   = 1'b0;
         end
         CMD_LOAD: begin
            count_d = load_value;
         end
         CMD_UP: begin
            count_d = sum[WIDTH-1:0];
            if (sum[WIDTH]) begin
               tc_d = 1'b1;
               if (mode_sat) begin
                  count_d = '1;
                  sat_d   = 1'b1;
               end
            end
         end
         CMD_DOWN: begin
            count_d = diff[WIDTH-1:0];
            if (diff[WIDTH]) begin
               tc_d = 1'b1;
               if (mode_sat) begin
                  count_d = '0;
                  sat_d   = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Channel state registers; async reset clears everything including pending tc.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!sys_rst_n) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         sat_q   <= sat_d;
      end
   end

   assign count    = count_q;
   assign tc_pulse = tc_q;
   assign sat_flag = sat_q;

endmodule

// File: rtl/ctrl_counter_bank.sv
// N_CH-channel up/down/load counter bank with a coherent snapshot for
// host readback and a free-running heartbeat counter.
module ctrl_counter_bank
   import ctrl_counter_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int WIDTH  = 32,
   parameter int STEP_W = 8,
   parameter int FREE_W = 32
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic [N_CH-1:0]       trig_rst,
   input  logic [N_CH-1:0]       trig_up,
   input  logic [N_CH-1:0]       trig_down,
   input  logic [N_CH-1:0]       trig_load,
   input  logic [WIDTH-1:0]      load_value,
   input  logic [STEP_W-1:0]     step,
   input  logic [N_CH-1:0]       mode_sat,
   input  logic                  snap_req,
   output logic [N_CH*WIDTH-1:0] count,
   output logic [N_CH*WIDTH-1:0] snap_data,
   output logic                  snap_valid,
   output logic [N_CH-1:0]       tc_pulse,
   output logic [N_CH-1:0]       sat_flag,
   output logic [FREE_W-1:0]     free_cnt,
   output logic                  heartbeat
);

   logic [N_CH*WIDTH-1:0] snap_q, snap_d;
   logic                  snap_valid_q, snap_valid_d;
   logic [FREE_W-1:0]     free_q, free_d;

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      cmd_e cmd;
      assign cmd = cmd_decode(trig_rst[i], trig_load[i], trig_up[i], trig_down[i]);

      ctrl_counter_chan #(
         .WIDTH  (WIDTH),
         .STEP_W (STEP_W)
      ) u_chan (
         .sys_clk    (sys_clk),
         .sys_rst_n  (sys_rst_n),
         .cmd        (cmd),
         .load_value (load_value),
         .step       (step),
         .mode_sat   (mode_sat[i]),
         .count      (count[i*WIDTH +: WIDTH]),
         .tc_pulse   (tc_pulse[i]),
         .sat_flag   (sat_flag[i])
      );
   end

   // Snapshot captures the registered counts, so same-cycle triggers are excluded.
   always_comb begin
      snap_d       = snap_req ? count : snap_q;
      snap_valid_d = snap_req;
      free_d       = free_q + 1'b1;
   end

   // Snapshot and free-running counter registers.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      // NOTE: snapshot is a register bank, not a memory, so it is reset like any flop.
      if (!sys_rst_n) begin
         snap_q       <= '0;
         snap_valid_q <= 1'b0;
         free_q       <= '0;
      end else begin
         snap_q       <= snap_d;
         snap_valid_q <= snap_valid_d;
         free_q       <= free_d;
      end
   end

   assign snap_data  = snap_q;
   assign snap_valid = snap_valid_q;
   assign free_cnt   = free_q;
   assign heartbeat  = free_q[FREE_W-2];

endmodule

// File: tb/tb_ctrl_counter_bank.sv
// Directed bench for ctrl_counter_bank with 8-bit counters.
module tb_ctrl_counter_bank;

   localparam int N_CH   = 4;
   localparam int WIDTH  = 8;
   localparam int STEP_W = 8;
   localparam int FREE_W = 32;

   logic                  sys_clk;
   logic                  sys_rst_n;
   logic [N_CH-1:0]       trig_rst, trig_up, trig_down, trig_load, mode_sat;
   logic [WIDTH-1:0]      load_value;
   logic [STEP_W-1:0]     step;
   logic                  snap_req;
   logic [N_CH*WIDTH-1:0] count, snap_data;
   logic                  snap_valid;
   logic [N_CH-1:0]       tc_pulse, sat_flag;
   logic [FREE_W-1:0]     free_cnt;
   logic                  heartbeat;

   int n_cmp = 0;
   int n_bad = 0;

   ctrl_counter_bank #(
      .N_CH(N_CH), .WIDTH(WIDTH), .STEP_W(STEP_W), .FREE_W(FREE_W)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .trig_rst(trig_rst), .trig_up(trig_up), .trig_down(trig_down), .trig_load(trig_load),
      .load_value(load_value), .step(step), .mode_sat(mode_sat), .snap_req(snap_req),
      .count(count), .snap_data(snap_data), .snap_valid(snap_valid),
      .tc_pulse(tc_pulse), .sat_flag(sat_flag), .free_cnt(free_cnt), .heartbeat(heartbeat)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   function automatic logic [WIDTH-1:0] ch(input logic [N_CH*WIDTH-1:0] v, input int i);
      return v[i*WIDTH +: WIDTH];
   endfunction

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clear_trigs();
      trig_rst = '0; trig_up = '0; trig_down = '0; trig_load = '0; snap_req = 1'b0;
   endtask

   task automatic load_ch(input int i, input logic [WIDTH-1:0] v);
      load_value   = v;
      trig_load[i] = 1'b1;
      tick();
      clear_trigs();
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      clear_trigs();
      load_value = '0; step = '0; mode_sat = '0;
      repeat (3) tick();
      n_cmp++;
      if ({count, snap_data, snap_valid, tc_pulse, sat_flag, free_cnt, heartbeat} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: count=%h snap=%h sv=%b tc=%b sat=%b free=%h hb=%b required all 0",
                  count, snap_data, snap_valid, tc_pulse, sat_flag, free_cnt, heartbeat);
      end
      sys_rst_n = 1'b1;
      repeat (10) tick();
      n_cmp++;
      if (free_cnt !== 32'd10) begin
         n_bad++; $display("FAIL reset_free_cnt: got %0d required 10", free_cnt);
      end
      n_cmp++;
      if (count !== '0) begin
         n_bad++; $display("FAIL reset_count_idle: got %h required 0", count);
      end
   endtask

   task automatic test_wrap();
      load_ch(0, 8'hFE);
      n_cmp++;
      if (ch(count, 0) !== 8'hFE) begin
         n_bad++; $display("FAIL wrap_load: got %h required fe", ch(count, 0));
      end
      n_cmp++;
      if (tc_pulse !== 4'b0000) begin
         n_bad++; $display("FAIL wrap_load_no_tc: got %b required 0000", tc_pulse);
      end
      step = 8'd3; trig_up[0] = 1'b1;
      tick(); clear_trigs();
      n_cmp++;
      if (ch(count, 0) !== 8'h01) begin
         n_bad++; $display("FAIL wrap_up_count: got %h required 01", ch(count, 0));
      end
      n_cmp++;
      if (tc_pulse !== 4'b0001) begin
         n_bad++; $display("FAIL wrap_up_tc: got %b required 0001", tc_pulse);
      end
      n_cmp++;
      if (sat_flag[0] !== 1'b0) begin
         n_bad++; $display("FAIL wrap_no_sat: got %b required 0", sat_flag[0]);
      end
      tick();
      n_cmp++;
      if (tc_pulse !== 4'b0000) begin
         n_bad++; $display("FAIL wrap_tc_one_cycle: got %b required 0000", tc_pulse);
      end
      // 0x01 - 2 borrows in wrap mode -> 0xFF
      step = 8'd2; trig_down[0] = 1'b1;
      tick(); clear_trigs();
      n_cmp++;
      if (ch(count, 0) !== 8'hFF || tc_pulse !== 4'b0001 || sat_flag !== 4'b0000) begin
         n_bad++; $display("FAIL wrap_down: count=%h tc=%b sat=%b required ff 0001 0000",
                           ch(count, 0), tc_pulse, sat_flag);
      end
   endtask

   task automatic test_saturate();
      mode_sat[1] = 1'b1;
      load_ch(1, 8'h02);
      step = 8'd5; trig_down[1] = 1'b1;
      tick(); clear_trigs();
      n_cmp++;
      if (ch(count, 1) !== 8'h00 || tc_pulse !== 4'b0010 || sat_flag[1] !== 1'b1) begin
         n_bad++; $display("FAIL sat_under: count=%h tc=%b sat=%b required 00 0010 1",
                           ch(count, 1), tc_pulse, sat_flag[1]);
      end
      // another step while at the limit pulses again
      trig_down[1] = 1'b1;
      tick(); clear_trigs();
      n_cmp++;
      if (ch(count, 1) !== 8'h00 || tc_pulse !== 4'b0010) begin
         n_bad++; $display("FAIL sat_at_limit: count=%h tc=%b required 00 0010", ch(count, 1), tc_pulse);
      end
      trig_rst[1] = 1'b1;
      tick(); clear_trigs();
      n_cmp++;
      if (ch(count, 1) !== 8'h00 || sat_flag[1] !== 1'b0 || tc_pulse !== 4'b0000) begin
         n_bad++; $display("FAIL sat_rst: count=%h sat=%b tc=%b required 00 0 0000",
                           ch(count, 1), sat_flag[1], tc_pulse);
      end
      // exact landing on max does not clamp
      load_ch(1, 8'hFC);
      step = 8'd3; trig_up[1] = 1'b1;
      tick(); clear_trigs();
      n_cmp++;
      if (ch(count, 1) !== 8'hFF || tc_pulse !== 4'b0000 || sat_flag[1] !== 1'b0) begin
         n_bad++; $display("FAIL sat_exact_max: count=%h tc=%b sat=%b required ff 0000 0",
                           ch(count, 1), tc_pulse, sat_flag[1]);
      end
      trig_up[1] = 1'b1;
      tick(); clear_trigs();
      n_cmp++;
      if (ch(count, 1) !== 8'hFF || tc_pulse !== 4'b0010 || sat_flag[1] !== 1'b1) begin
         n_bad++; $display("FAIL sat_over: count=%h tc=%b sat=%b required ff 0010 1",
                           ch(count, 1), tc_pulse, sat_flag[1]);
      end
      // load keeps sat_flag and gives no tc
      load_ch(1, 8'h40);
      n_cmp++;
      if (ch(count, 1) !== 8'h40 || tc_pulse !== 4'b0000 || sat_flag[1] !== 1'b1) begin
         n_bad++; $display("FAIL sat_load_keeps_flag: count=%h tc=%b sat=%b required 40 0000 1",
                           ch(count, 1), tc_pulse, sat_flag[1]);
      end
   endtask

   task automatic test_priority();
      load_value = 8'h55; step = 8'd1;
      trig_rst[2] = 1'b1; trig_load[2] = 1'b1; trig_up[2] = 1'b1;
      tick(); clear_trigs();
      n_cmp++;
      if (ch(count, 2) !== 8'h00) begin
         n_bad++; $display("FAIL prio_rst: got %h required 00", ch(count, 2));
      end
      trig_load[2] = 1'b1; trig_up[2] = 1'b1;
      tick(); clear_trigs();
      n_cmp++;
      if (ch(count, 2) !== 8'h55) begin
         n_bad++; $display("FAIL prio_load: got %h required 55", ch(count, 2));
      end
      step = 8'hFF; trig_up[2] = 1'b1; trig_down[2] = 1'b1;
      tick(); clear_trigs();
      n_cmp++;
      if (ch(count, 2) !== 8'h55 || tc_pulse !== 4'b0000) begin
         n_bad++; $display("FAIL prio_up_down: count=%h tc=%b required 55 0000", ch(count, 2), tc_pulse);
      end
      // step 0 leaves count unchanged
      step = 8'd0; trig_up[2] = 1'b1;
      tick(); clear_trigs();
      n_cmp++;
      if (ch(count, 2) !== 8'h55) begin
         n_bad++; $display("FAIL step_zero: got %h required 55", ch(count, 2));
      end
   endtask

   task automatic test_snapshot();
      load_ch(3, 8'h10);
      step = 8'd1; trig_up[3] = 1'b1; snap_req = 1'b1;
      tick(); clear_trigs();
      n_cmp++;
      if (ch(snap_data, 3) !== 8'h10 || ch(count, 3) !== 8'h11 || snap_valid !== 1'b1) begin
         n_bad++; $display("FAIL snap_coherent: snap=%h count=%h valid=%b required 10 11 1",
                           ch(snap_data, 3), ch(count, 3), snap_valid);
      end
      n_cmp++;
      if (ch(snap_data, 2) !== 8'h55 || ch(snap_data, 0) !== 8'hFF) begin
         n_bad++; $display("FAIL snap_other_ch: ch2=%h ch0=%h required 55 ff",
                           ch(snap_data, 2), ch(snap_data, 0));
      end
      tick();
      n_cmp++;
      if (snap_valid !== 1'b0 || ch(snap_data, 3) !== 8'h10) begin
         n_bad++; $display("FAIL snap_valid_one_cycle: valid=%b snap=%h required 0 10",
                           snap_valid, ch(snap_data, 3));
      end
   endtask

   task automatic test_back_to_back();
      step = 8'd1; trig_up[3] = 1'b1; snap_req = 1'b1;
      tick();
      n_cmp++;
      if (ch(snap_data, 3) !== 8'h11 || snap_valid !== 1'b1) begin
         n_bad++; $display("FAIL b2b_first: snap=%h valid=%b required 11 1", ch(snap_data, 3), snap_valid);
      end
      tick(); clear_trigs();
      n_cmp++;
      if (ch(snap_data, 3) !== 8'h12 || snap_valid !== 1'b1 || ch(count, 3) !== 8'h13) begin
         n_bad++; $display("FAIL b2b_second: snap=%h valid=%b count=%h required 12 1 13",
                           ch(snap_data, 3), snap_valid, ch(count, 3));
      end
   endtask

   task automatic test_async_reset();
      step = 8'd1; trig_up = 4'hF;
      repeat (3) tick();
      #2;
      sys_rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({count, snap_data, snap_valid, tc_pulse, sat_flag, free_cnt} !== '0) begin
         n_bad++;
         $display("FAIL async_reset: count=%h snap=%h sv=%b tc=%b sat=%b free=%h required all 0",
                  count, snap_data, snap_valid, tc_pulse, sat_flag, free_cnt);
      end
      tick();
      clear_trigs();
      trig_up[0] = 1'b1;
      sys_rst_n = 1'b1;
      repeat (3) tick();
      clear_trigs();
      n_cmp++;
      if (ch(count, 0) !== 8'h03 || free_cnt !== 32'd3 || count[31:8] !== '0) begin
         n_bad++; $display("FAIL async_resume: count=%h free=%0d required 00000003 3", count, free_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_saturate();
      test_priority();
      test_snapshot();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
